uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receiver. It captures each valid byte pulse into a first-word-fall-through FIFO and flags overruns and parity-errored frames. It exposes pop/status/threshold-interrupt signals to the peripheral bus register block. Purely synchronous to the receiver's clock; no CDC.

Parameters:
DEPTH, 16, number of byte entries; power of two, >= 2
CNT_W, $clog2(DEPTH)+1, localparam width of occupancy count and threshold

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
rx_valid_i  input  1  single-cycle pulse from receiver: rx_data_i holds a good byte
rx_data_i  input  8  received byte, qualified by rx_valid_i
rx_parity_error_i  input  1  receiver parity-error level; rising edge marks one bad frame
flush_i  input  1  synchronous clear of FIFO contents
rd_en_i  input  1  pop head entry (ignored when empty)
thresh_i  input  CNT_W  interrupt threshold; 0 disables interrupt
clr_err_i  input  1  clears sticky error flags
rd_data_o  output  8  head entry (FWFT); 8'h00 when empty
empty_o  output  1  no entries
full_o  output  1  DEPTH entries
count_o  output  CNT_W  current occupancy 0..DEPTH
thresh_irq_o  output  1  level: thresh_i != 0 && count_o >= thresh_i
overrun_o  output  1  sticky: byte dropped because FIFO full
parity_err_o  output  1  sticky: parity-errored frame seen

Behaviour:
- Reset (async assert, sync release): wr_ptr=rd_ptr=0, count=0, empty_o=1, full_o=0, thresh_irq_o=0, overrun_o=0, parity_err_o=0, parity edge-detect register=0, rd_data_o=8'h00. Storage array is not reset.
- Pointers are ADDR_W=$clog2(DEPTH) bits and wrap naturally DEPTH-1 -> 0. The count register is the single source for empty/full (empty = count==0, full = count==DEPTH).
- Push: rx_valid_i && (!full || pop_acc). Writes mem[wr_ptr], wr_ptr++.
- Pop: pop_acc = rd_en_i && !empty. rd_ptr++.
- Count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full + rx_valid_i + rd_en_i in the same cycle: push accepted, count stays DEPTH, no overrun.
- Full + rx_valid_i without pop: byte dropped, overrun_o set next cycle, contents unchanged.
- Empty + rx_valid_i + rd_en_i: pop ignored, push accepted, count becomes 1.
- Latency: byte pushed at edge N appears on rd_data_o with empty_o=0 after edge N. No bypass in the same cycle as the push.
- rd_data_o is combinational from mem[rd_ptr], gated to 8'h00 when empty.
- Parity: registered edge detect on rx_parity_error_i. A 0->1 edge sets parity_err_o. No data is stored for that frame.
- Sticky flags: clr_err_i clears both. If set and clear coincide, set wins.
- flush_i has priority over push/pop: pointers and count go to 0 on the next edge, and a concurrent rx_valid_i byte is discarded. Sticky flags are unaffected by flush.
- thresh_irq_o is combinational from registered count and thresh_i.
- thresh_i > DEPTH: interrupt never fires.

Decomposition:
- Shared package uart_pkg holds:
  - UART_RX_FIFO_DEPTH default (16)
  - a function for CNT_W
  - a packed struct uart_rx_status_t {empty, full, overrun, parity_err, thresh_irq} for the register block's status word
- No sub-module. Storage is an inferred array inside this module.

Test Plan:
- Reset, then push 8'hA5, 8'h3C on separate cycles -> count_o=2, rd_data_o=8'hA5. Pop -> rd_data_o=8'h3C, count_o=1. Pop -> empty_o=1, rd_data_o=8'h00.
- Push bytes 0x00..0x0F (DEPTH=16) -> full_o=1, count_o=16. Push 0xFF -> overrun_o=1, count_o=16. Drain -> 0x00..0x0F in order with 0xFF absent. Continue to 40 push/pop pairs to exercise pointer wrap.
- Full FIFO, rx_valid_i=1 with 0x77 and rd_en_i=1 same cycle -> count_o stays 16, overrun_o=0, 0x77 read out last.
- thresh_i=4: push 3 -> thresh_irq_o=0; push 4th -> thresh_irq_o=1; pop 1 -> 0. thresh_i=0 with 16 entries -> thresh_irq_o=0.
- rx_parity_error_i held high 5 cycles -> parity_err_o=1, count_o unchanged. Assert clr_err_i on the same cycle as a new 0->1 edge -> parity_err_o stays 1. clr_err_i alone -> 0.
- Five entries plus flush_i with simultaneous rx_valid_i -> count_o=0, empty_o=1, sticky flags retained. Assert rst_n low mid-stream -> all outputs take reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receive-path definitions: FIFO sizing and the status word seen by the register block.
package uart_pkg;

    localparam int UART_RX_FIFO_DEPTH = 16;

    // The occupancy count must represent DEPTH itself, so it needs one bit beyond the address.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic overrun;
        logic parity_err;
        logic thresh_irq;
    } uart_rx_status_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// UART receive FWFT byte FIFO with sticky overrun/parity flags and a threshold interrupt.
// A byte pushed at edge N is visible after edge N; when full, a push is dropped unless a pop accepts it in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_RX_FIFO_DEPTH,
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_valid_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_parity_error_i,
    input  logic             flush_i,
    input  logic             rd_en_i,
    input  logic [CNT_W-1:0] thresh_i,
    input  logic             clr_err_i,
    output logic [7:0]       rd_data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o,
    output logic             thresh_irq_o,
    output logic             overrun_o,
    output logic             parity_err_o
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_par_q;
    logic              r_overrun;
    logic              r_parity_err;

    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_par_rise;
    uart_rx_status_t   w_status;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_pop      = rd_en_i && !w_empty;
    assign w_push     = rx_valid_i && (!w_full || w_pop);
    // A byte discarded by a flush is not an overrun; only a genuinely full FIFO drops.
    assign w_drop     = rx_valid_i && w_full && !w_pop && !flush_i;
    assign w_par_rise = rx_parity_error_i && !r_par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush_i) begin
            r_mem[r_wr_ptr] <= rx_data_i;
        end
    end

    // Set beats clear when both happen in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_q      <= 1'b0;
            r_overrun    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_par_q <= rx_parity_error_i;
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_err_i) begin
                r_overrun <= 1'b0;
            end
            if (w_par_rise) begin
                r_parity_err <= 1'b1;
            end else if (clr_err_i) begin
                r_parity_err <= 1'b0;
            end
        end
    end

    assign w_status.empty      = w_empty;
    assign w_status.full       = w_full;
    assign w_status.overrun    = r_overrun;
    assign w_status.parity_err = r_parity_err;
    assign w_status.thresh_irq = (thresh_i != '0) && (r_count >= thresh_i);

    assign rd_data_o    = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign count_o      = r_count;
    assign empty_o      = w_status.empty;
    assign full_o       = w_status.full;
    assign overrun_o    = w_status.overrun;
    assign parity_err_o = w_status.parity_err;
    assign thresh_irq_o = w_status.thresh_irq;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized checks of uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rx_valid_i = 1'b0;
    logic [7:0]       rx_data_i = 8'h00;
    logic             rx_parity_error_i = 1'b0;
    logic             flush_i = 1'b0;
    logic             rd_en_i = 1'b0;
    logic [CNT_W-1:0] thresh_i = '0;
    logic             clr_err_i = 1'b0;
    logic [7:0]       rd_data_o;
    logic             empty_o;
    logic             full_o;
    logic [CNT_W-1:0] count_o;
    logic             thresh_irq_o;
    logic             overrun_o;
    logic             parity_err_o;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
        .rx_parity_error_i(rx_parity_error_i), .flush_i(flush_i),
        .rd_en_i(rd_en_i), .thresh_i(thresh_i), .clr_err_i(clr_err_i),
        .rd_data_o(rd_data_o), .empty_o(empty_o), .full_o(full_o),
        .count_o(count_o), .thresh_irq_o(thresh_irq_o),
        .overrun_o(overrun_o), .parity_err_o(parity_err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [7:0] q[$];
    bit m_ovr = 0;
    bit m_perr = 0;
    bit m_prev = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".rd_data"}, rd_data_o, (n > 0) ? q[0] : 8'h00);
        chk({tag, ".empty"}, empty_o, n == 0);
        chk({tag, ".full"}, full_o, n == DEPTH);
        chk({tag, ".count"}, count_o, n);
        chk({tag, ".irq"}, thresh_irq_o, (thresh_i != 0) && (n >= int'(thresh_i)));
        chk({tag, ".overrun"}, overrun_o, m_ovr);
        chk({tag, ".parity"}, parity_err_o, m_perr);
    endtask

    task automatic model_reset();
        q.delete();
        m_ovr = 0;
        m_perr = 0;
        m_prev = 0;
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then compare everything.
    task automatic cyc(input bit rxv, input logic [7:0] d, input bit rd,
                       input bit fl, input bit par, input bit clr, input string tag);
        bit drop;
        bit rise;
        rx_valid_i = rxv;
        rx_data_i = d;
        rd_en_i = rd;
        flush_i = fl;
        rx_parity_error_i = par;
        clr_err_i = clr;
        @(posedge clk);
        drop = 0;
        if (fl) begin
            q.delete();
        end else begin
            if (rd && q.size() > 0) void'(q.pop_front());
            if (rxv) begin
                if (q.size() < DEPTH) q.push_back(d);
                else drop = 1;
            end
        end
        rise = par && !m_prev;
        m_prev = par;
        if (drop) m_ovr = 1; else if (clr) m_ovr = 0;
        if (rise) m_perr = 1; else if (clr) m_perr = 0;
        #1;
        rx_valid_i = 0;
        rd_en_i = 0;
        flush_i = 0;
        clr_err_i = 0;
        check_all(tag);
    endtask

    initial begin
        logic [7:0] b;
        #1;
        chk("reset.rd_data", rd_data_o, 8'h00);
        chk("reset.empty", empty_o, 1);
        chk("reset.count", count_o, 0);
        check_all("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic two-byte FWFT ordering
        cyc(1, 8'hA5, 0, 0, 0, 0, "push_a5");
        cyc(1, 8'h3C, 0, 0, 0, 0, "push_3c");
        chk("two.count", count_o, 2);
        chk("two.head", rd_data_o, 8'hA5);
        cyc(0, 8'h00, 1, 0, 0, 0, "pop1");
        chk("pop1.head", rd_data_o, 8'h3C);
        chk("pop1.count", count_o, 1);
        cyc(0, 8'h00, 1, 0, 0, 0, "pop2");
        chk("pop2.empty", empty_o, 1);
        chk("pop2.head", rd_data_o, 8'h00);

        // Fill, overrun, drain in order
        for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i), 0, 0, 0, 0, "fill");
        chk("fill.full", full_o, 1);
        chk("fill.count", count_o, 16);
        cyc(1, 8'hFF, 0, 0, 0, 0, "over");
        chk("over.flag", overrun_o, 1);
        chk("over.count", count_o, 16);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain.order", rd_data_o, i);
            cyc(0, 8'h00, 1, 0, 0, 0, "drain");
        end
        chk("drain.empty", empty_o, 1);
        for (int i = 0; i < 40; i++) begin
            cyc(1, 8'($urandom_range(0, 255)), 0, 0, 0, 0, "wrap_push");
            cyc(0, 8'h00, 1, 0, 0, 0, "wrap_pop");
        end
        cyc(0, 8'h00, 0, 0, 0, 1, "clr_ovr");
        chk("clr_ovr.flag", overrun_o, 0);

        // Full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) cyc(1, 8'($urandom_range(0, 255)), 0, 0, 0, 0, "fill2");
        cyc(1, 8'h77, 1, 0, 0, 0, "full_pp");
        chk("full_pp.count", count_o, 16);
        chk("full_pp.ovr", overrun_o, 0);
        for (int i = 0; i < DEPTH - 1; i++) cyc(0, 8'h00, 1, 0, 0, 0, "drain2");
        chk("full_pp.last", rd_data_o, 8'h77);
        cyc(0, 8'h00, 1, 0, 0, 0, "drain2_last");
        cyc(1, 8'h5A, 1, 0, 0, 0, "empty_pp");
        chk("empty_pp.count", count_o, 1);
        cyc(0, 8'h00, 1, 0, 0, 0, "empty_pp_pop");

        // Threshold interrupt
        thresh_i = 5'd4;
        for (int i = 0; i < 3; i++) cyc(1, 8'(8'h40 + i), 0, 0, 0, 0, "thr_push");
        chk("thr3.irq", thresh_irq_o, 0);
        cyc(1, 8'h43, 0, 0, 0, 0, "thr_push4");
        chk("thr4.irq", thresh_irq_o, 1);
        cyc(0, 8'h00, 1, 0, 0, 0, "thr_pop");
        chk("thr_pop.irq", thresh_irq_o, 0);
        thresh_i = 5'd0;
        for (int i = 0; i < 13; i++) cyc(1, 8'($urandom_range(0, 255)), 0, 0, 0, 0, "thr_fill");
        chk("thr0.count", count_o, 16);
        chk("thr0.irq", thresh_irq_o, 0);
        thresh_i = 5'd17;
        #1;
        check_all("thr17");
        chk("thr17.irq", thresh_irq_o, 0);
        thresh_i = 5'd16;
        #1;
        chk("thr16.irq", thresh_irq_o, 1);
        cyc(0, 8'h00, 0, 1, 0, 0, "thr_flush");

        // Parity edge detect and sticky clear
        for (int i = 0; i < 5; i++) cyc(0, 8'h00, 0, 0, 1, 0, "par_hold");
        chk("par.flag", parity_err_o, 1);
        chk("par.count", count_o, 0);
        cyc(0, 8'h00, 0, 0, 0, 0, "par_low");
        cyc(0, 8'h00, 0, 0, 1, 1, "par_set_clr");
        chk("par_set_clr.flag", parity_err_o, 1);
        cyc(0, 8'h00, 0, 0, 0, 1, "par_clr");
        chk("par_clr.flag", parity_err_o, 0);

        // Flush with concurrent push keeps sticky flags
        for (int i = 0; i < 5; i++) cyc(1, 8'($urandom_range(0, 255)), 0, 0, 0, 0, "fl_push");
        cyc(0, 8'h00, 0, 0, 1, 0, "fl_par");
        cyc(1, 8'hEE, 0, 1, 0, 0, "flush");
        chk("flush.count", count_o, 0);
        chk("flush.empty", empty_o, 1);
        chk("flush.parity", parity_err_o, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bit rxv;
            bit rd;
            if (i % 50 == 0) thresh_i = CNT_W'($urandom_range(0, 20));
            if ((i / 100) % 2 == 0) begin
                rxv = ($urandom_range(0, 3) != 0);
                rd = ($urandom_range(0, 3) == 0);
            end else begin
                rxv = ($urandom_range(0, 3) == 0);
                rd = ($urandom_range(0, 3) != 0);
            end
            b = 8'($urandom_range(0, 255));
            cyc(rxv, b, rd, $urandom_range(0, 39) == 0,
                (rx_parity_error_i ^ ($urandom_range(0, 7) == 0)),
                $urandom_range(0, 9) == 0, "rand");
        end

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) cyc(1, 8'($urandom_range(0, 255)), 0, 0, 1, 0, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        rx_parity_error_i = 0;
        chk("arst.empty", empty_o, 1);
        chk("arst.count", count_o, 0);
        chk("arst.rd_data", rd_data_o, 8'h00);
        check_all("arst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1, 8'h99, 0, 0, 0, 0, "post_rst");
        chk("post_rst.head", rd_data_o, 8'h99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
